// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage directly upstream of the control path. Holds the PC, issues
// word fetches to instruction memory and absorbs memory wait-states. Presents
// one latched 32-bit instruction (with a fault flag) to the decoder and
// advances only when the decoder consumes it. A redirect port loads a new PC
// and may abort a fetch that is already in flight.
//
// Parameters
//   PC_WIDTH        width of the PC and instruction address
//   RESET_PC        PC loaded on reset (low two bits are ignored)
//
// Ports
//   clk             system clock, all state on rising edge
//   resetn          asynchronous, active-low reset
//   instr_req       fetch request to instruction memory (decoded from state)
//   instr_addr      fetch address, always equal to pc (word aligned)
//   instr_rdata     memory read data, valid when instr_req & ~wait_instr
//   wait_instr      memory not ready; response completes when low with req high
//   instr_segv_in   memory access fault, sampled with the response
//   instruction     latched instruction presented to the control path
//   instr_valid     instruction holds a fetched, unconsumed word
//   instr_segv      fetch at pc faulted; stage halted until redirect/reset
//   pc              address of the presented/pending instruction
//   pc_inc          decoder consumes the instruction (only acted on if valid)
//   wait_data       data-side stall; blocks consumption while high
//   redirect_valid  load redirect_pc, discard current/in-flight instruction
//   redirect_pc     new PC; low two bits forced to zero
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter int unsigned            PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
   input  logic                clk,
   input  logic                resetn,
   output logic                instr_req,
   output logic [PC_WIDTH-1:0] instr_addr,
   input  logic [31:0]         instr_rdata,
   input  logic                wait_instr,
   input  logic                instr_segv_in,
   output logic [31:0]         instruction,
   output logic                instr_valid,
   output logic                instr_segv,
   output logic [PC_WIDTH-1:0] pc,
   input  logic                pc_inc,
   input  logic                wait_data,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_pc
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_ISSUE = 2'd1,
      S_FAULT = 2'd2
   } state_e;

   localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
   localparam logic [PC_WIDTH-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]         instr_q, instr_d;
   logic                valid_q, valid_d;
   logic                segv_q, segv_d;
   logic                flush_q, flush_d;

   logic                response;
   logic                consume;

   // A response completes on any FETCH cycle where memory is not stalling.
   assign response = (state_q == S_FETCH) && !wait_instr;
   // ISSUE always has a valid word, so pc_inc is only qualified by the stall.
   assign consume  = (state_q == S_ISSUE) && pc_inc && !wait_data;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      segv_d  = segv_q;
      flush_d = flush_q;

      if (redirect_valid) begin
         // Redirect outranks everything on the same edge: a simultaneous
         // consume does not step the PC and a simultaneous response is lost.
         pc_d    = redirect_pc & ALIGN_MASK;
         valid_d = 1'b0;
         segv_d  = 1'b0;
         state_d = S_FETCH;
         // A stalled FETCH leaves one response owed for the old address; it
         // must be dropped. If the response lands this cycle nothing is owed,
         // and an already-flushed wait stays flushed (at most one outstanding).
         flush_d = (state_q == S_FETCH) && wait_instr;
      end else begin
         unique case (state_q)
            S_FETCH: begin
               if (response) begin
                  if (flush_q) begin
                     // Stale response for an aborted address: drop it and
                     // re-issue at the current pc.
                     flush_d = 1'b0;
                  end else if (instr_segv_in) begin
                     segv_d  = 1'b1;
                     state_d = S_FAULT;
                  end else begin
                     instr_d = instr_rdata;
                     valid_d = 1'b1;
                     state_d = S_ISSUE;
                  end
               end
            end

            S_ISSUE: begin
               if (consume) begin
                  valid_d = 1'b0;
                  pc_d    = pc_q + PC_STEP;
                  state_d = S_FETCH;
               end
            end

            S_FAULT: begin
               // Halted at the faulting address until redirect or reset.
               state_d = S_FAULT;
            end

            default: begin
               state_d = S_FETCH;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_FETCH;
         pc_q    <= PC_INIT;
         instr_q <= '0;
         valid_q <= 1'b0;
         segv_q  <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         segv_q  <= segv_d;
         flush_q <= flush_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // Gated by resetn so no request is seen by memory while reset is asserted.
   assign instr_req   = resetn && (state_q == S_FETCH);
   assign instr_addr  = pc_q & ALIGN_MASK;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign instr_segv  = segv_q;
   assign pc          = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   logic        clk;
   logic        resetn;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic [31:0] instr_rdata;
   logic        wait_instr;
   logic        instr_segv_in;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        instr_segv;
   logic [31:0] pc;
   logic        pc_inc;
   logic        wait_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int unsigned n_cmp;
   int unsigned n_bad;

   instruction_fetch #(
      .PC_WIDTH (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .instr_req      (instr_req),
      .instr_addr     (instr_addr),
      .instr_rdata    (instr_rdata),
      .wait_instr     (wait_instr),
      .instr_segv_in  (instr_segv_in),
      .instruction    (instruction),
      .instr_valid    (instr_valid),
      .instr_segv     (instr_segv),
      .pc             (pc),
      .pc_inc         (pc_inc),
      .wait_data      (wait_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs applied before a rising edge and the outputs expected just after it.
   typedef struct {
      logic        wi;
      logic [31:0] rd;
      logic        sg;
      logic        inc;
      logic        wd;
      logic        rv;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic [31:0] ins;
      logic        vld;
      logic        sgv;
      logic [31:0] pcx;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic wi, input logic [31:0] rd, input logic sg,
                               input logic inc, input logic wd, input logic rv,
                               input logic [31:0] rpc, input logic req,
                               input logic [31:0] addr, input logic [31:0] ins,
                               input logic vld, input logic sgv, input logic [31:0] pcx);
      vec_t v;
      v.wi = wi; v.rd = rd; v.sg = sg; v.inc = inc; v.wd = wd; v.rv = rv; v.rpc = rpc;
      v.req = req; v.addr = addr; v.ins = ins; v.vld = vld; v.sgv = sgv; v.pcx = pcx;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                            input logic [31:0] ins, input logic vld, input logic sgv,
                            input logic [31:0] pcx);
      check({tag, ".instr_req"},   {31'b0, instr_req},   {31'b0, req});
      check({tag, ".instr_addr"},  instr_addr,           addr);
      check({tag, ".instruction"}, instruction,          ins);
      check({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, vld});
      check({tag, ".instr_segv"},  {31'b0, instr_segv},  {31'b0, sgv});
      check({tag, ".pc"},          pc,                   pcx);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      resetn = 1'b0; wait_instr = 1'b0; instr_rdata = 32'hDEADBEEF; instr_segv_in = 1'b0;
      pc_inc = 1'b0; wait_data = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

      //             wi  rd            sg inc wd rv rpc            req addr          ins           vld sgv pc
      // Basic fetch and consume
      vecs.push_back(mk(0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hDEADBEEF, 1, 0, 32'h0));
      vecs.push_back(mk(0, 32'h0,        0, 1, 0, 0, 32'h0,        1, 32'h4,        32'hDEADBEEF, 0, 0, 32'h4));
      // Three wait-states, then data-side stall on consume
      vecs.push_back(mk(1, 32'h11111111, 0, 0, 0, 0, 32'h0,        1, 32'h4,        32'hDEADBEEF, 0, 0, 32'h4));
      vecs.push_back(mk(1, 32'h11111111, 0, 0, 0, 0, 32'h0,        1, 32'h4,        32'hDEADBEEF, 0, 0, 32'h4));
      vecs.push_back(mk(1, 32'h11111111, 0, 0, 0, 0, 32'h0,        1, 32'h4,        32'hDEADBEEF, 0, 0, 32'h4));
      vecs.push_back(mk(0, 32'h11111111, 0, 0, 0, 0, 32'h0,        0, 32'h4,        32'h11111111, 1, 0, 32'h4));
      vecs.push_back(mk(0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 32'h4,        32'h11111111, 1, 0, 32'h4));
      vecs.push_back(mk(0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 32'h4,        32'h11111111, 1, 0, 32'h4));
      vecs.push_back(mk(0, 32'h0,        0, 1, 0, 0, 32'h0,        1, 32'h8,        32'h11111111, 0, 0, 32'h8));
      // Redirect beats a same-cycle response; then fault at 0x40
      vecs.push_back(mk(0, 32'h22222222, 0, 0, 0, 1, 32'h40,       1, 32'h40,       32'h11111111, 0, 0, 32'h40));
      vecs.push_back(mk(0, 32'h33333333, 1, 0, 0, 0, 32'h0,        0, 32'h40,       32'h11111111, 0, 1, 32'h40));
      vecs.push_back(mk(0, 32'h0,        0, 1, 0, 0, 32'h0,        0, 32'h40,       32'h11111111, 0, 1, 32'h40));
      vecs.push_back(mk(0, 32'h99999999, 0, 0, 0, 0, 32'h0,        0, 32'h40,       32'h11111111, 0, 1, 32'h40));
      vecs.push_back(mk(0, 32'h0,        0, 0, 0, 1, 32'h100,      1, 32'h100,      32'h11111111, 0, 0, 32'h100));
      vecs.push_back(mk(0, 32'h44444444, 0, 0, 0, 0, 32'h0,        0, 32'h100,      32'h44444444, 1, 0, 32'h100));
      // Redirect during an outstanding fetch: stale response must be dropped
      vecs.push_back(mk(0, 32'h0,        0, 0, 0, 1, 32'h10,       1, 32'h10,       32'h44444444, 0, 0, 32'h10));
      vecs.push_back(mk(1, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'h10,       32'h44444444, 0, 0, 32'h10));
      vecs.push_back(mk(1, 32'h0,        0, 0, 0, 1, 32'h203,      1, 32'h200,      32'h44444444, 0, 0, 32'h200));
      vecs.push_back(mk(1, 32'h0,        0, 0, 0, 1, 32'h200,      1, 32'h200,      32'h44444444, 0, 0, 32'h200));
      vecs.push_back(mk(0, 32'hBADBAD00, 0, 0, 0, 0, 32'h0,        1, 32'h200,      32'h44444444, 0, 0, 32'h200));
      vecs.push_back(mk(0, 32'h55555555, 0, 0, 0, 0, 32'h0,        0, 32'h200,      32'h55555555, 1, 0, 32'h200));
      // Redirect wins over a simultaneous consume
      vecs.push_back(mk(0, 32'h0,        0, 1, 0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h55555555, 0, 0, 32'hFFFFFFFC));
      // PC wrap
      vecs.push_back(mk(0, 32'h66666666, 0, 0, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 32'h66666666, 1, 0, 32'hFFFFFFFC));
      vecs.push_back(mk(0, 32'h0,        0, 1, 0, 0, 32'h0,        1, 32'h0,        32'h66666666, 0, 0, 32'h0));
      vecs.push_back(mk(0, 32'h77777777, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h77777777, 1, 0, 32'h0));
      // Redirect from ISSUE with memory stalled must not arm a flush
      vecs.push_back(mk(1, 32'h0,        0, 0, 0, 1, 32'h80,       1, 32'h80,       32'h77777777, 0, 0, 32'h80));
      vecs.push_back(mk(0, 32'h88888888, 0, 0, 0, 0, 32'h0,        0, 32'h80,       32'h88888888, 1, 0, 32'h80));

      // Reset state, with clocks running
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

      @(negedge clk);
      resetn = 1'b1;
      #1;
      check({"first.instr_req"}, {31'b0, instr_req}, 32'h1);

      for (int i = 0; i < vecs.size(); i++) begin
         wait_instr     = vecs[i].wi;
         instr_rdata    = vecs[i].rd;
         instr_segv_in  = vecs[i].sg;
         pc_inc         = vecs[i].inc;
         wait_data      = vecs[i].wd;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].ins,
                   vecs[i].vld, vecs[i].sgv, vecs[i].pcx);
         @(negedge clk);
      end

      // Asynchronous reset mid-operation (stage is in ISSUE at 0x80)
      pc_inc = 1'b0; redirect_valid = 1'b0; wait_instr = 1'b0;
      resetn = 1'b0;
      #1;
      check_all("async_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

      @(negedge clk);
      resetn = 1'b1;
      instr_rdata = 32'hCAFEF00D;
      #1;
      check("post_rst.instr_req", {31'b0, instr_req}, 32'h1);
      check("post_rst.instr_addr", instr_addr, 32'h0);
      @(posedge clk);
      #1;
      check_all("post_rst.resp", 1'b0, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Safety net so the run always ends on its own.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, required completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

endmodule
